sample_edge_monitor: RTL and testbench
======================================

SAMPLE_EDGE_MONITOR -- requirements
Module: sample_edge_monitor

Interface
REQ-001 The block SHALL have parameter CH, default 4, number of independent monitored channels.
REQ-002 The block SHALL have parameter W, default 1, bits per channel.
REQ-003 The block SHALL have parameter STABLE_MAX, default 8, consecutive unchanged samples that flag a stuck channel (>=1).
REQ-004 The block SHALL have parameter CNT_W, default 8, width of each per-channel change counter.
REQ-005 The block SHALL have port clk  input  1  sole clock, all sampling on posedge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port en  input  1  sample enable.
REQ-008 The block SHALL have port clr  input  1  clears counters and sticky flags.
REQ-009 The block SHALL have port din  input  CH*W  channel i at din[i*W +: W].
REQ-010 The block SHALL have port changed  output  CH  one-cycle pulse, sample differs from previous sample.
REQ-011 The block SHALL have port rose  output  CH  one-cycle pulse, channel bit 0 went 0->1.
REQ-012 The block SHALL have port fell  output  CH  one-cycle pulse, channel bit 0 went 1->0.
REQ-013 The block SHALL have port stuck_err  output  CH  sticky, channel unchanged for STABLE_MAX samples.
REQ-014 The block SHALL have port chg_cnt  output  CH*CNT_W  per-channel saturating change count.
REQ-015 The block SHALL have port armed  output  1  high once a reference sample is held.

Function
REQ-016 Each channel SHALL run its own FSM with states INIT (no reference sample), TRACK, STUCK.
REQ-017 INIT: on posedge with en=1, the block SHALL capture din as reference, go to TRACK, set armed, and emit no events.
REQ-018 TRACK/STUCK: on posedge with en=1, the block SHALL compare the current sample against the reference, then replace the reference with the current sample.
REQ-019 Event outputs SHALL be registered: a change sampled at edge n SHALL be visible from edge n until edge n+1 (one-cycle pulse).
REQ-020 rose/fell SHALL consider bit 0 only; changed SHALL consider all W bits.
REQ-021 Each channel SHALL keep a stable counter that resets to 0 on a change and increments by 1 on an unchanged sample, saturating at STABLE_MAX.
REQ-022 When the stable counter reaches STABLE_MAX, the block SHALL set stuck_err[i] at that same edge and move the channel to STUCK.
REQ-023 A change in STUCK SHALL return the channel to TRACK; stuck_err SHALL stay set until clr or rst.
REQ-024 chg_cnt[i] SHALL increment by 1 per change and hold at 2^CNT_W-1 (no wrap).
REQ-025 en=0 SHALL hold the reference, FSM, and all counters, and SHALL drive changed/rose/fell to 0.
REQ-026 clr=1 SHALL zero chg_cnt, stuck_err and the stable counters, and SHALL move STUCK channels to TRACK; it SHALL NOT clear the reference or armed.
REQ-027 If clr and a change occur at the same edge, clr SHALL win for counters and flags (result 0), and the changed/rose/fell pulses SHALL still be emitted.
REQ-028 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported at the same edge.

Reset
REQ-029 On rst=1 at posedge, the block SHALL drive all FSMs to INIT and all outputs to 0 (armed=0, chg_cnt=0, stuck_err=0, pulses=0).
REQ-030 rst SHALL override en and clr; a reset during operation SHALL discard the reference, and the first post-reset sample SHALL produce no event.

Configuration
REQ-031 With macro SAMPLE_EDGE_MONITOR_ASSERT_EN defined, the block SHALL compile in concurrent assertions on posedge clk, disabled by rst:
- changed[i] equals the sampled-value inequality of channel i versus its previous enabled sample once armed
- rose/fell are never both 1
- stuck_err never falls without clr/rst
- chg_cnt never decreases without clr/rst
Each assertion failure SHALL report $error with time and channel index.
REQ-032 Without the macro, the block SHALL contain no assertions, and its RTL behaviour SHALL be identical.

Verification (CH=4, W=2, STABLE_MAX=3, CNT_W=4)
REQ-033 rst 2 cycles, en=1, din ch0 = 0,1,1,0 -> no pulse on the first sample; rose[0] at sample 2; fell[0] at sample 4; chg_cnt[0]=2.
REQ-034 Hold ch1=2'b10 for 4 samples after arming -> stuck_err[1]=1 at the 3rd unchanged sample; a later change clears nothing; clr -> 0.
REQ-035 Toggle ch2 for 20 samples -> chg_cnt[2] saturates at 15.
REQ-036 en=0 for 5 cycles while din changes, then en=1 with unchanged din -> no pulses, counters frozen.
REQ-037 Drive clr on the same edge as a ch3 change 00->11 -> changed[3]=1, chg_cnt[3]=0; rst mid-stream -> armed=0, next sample produces no event.
REQ-038 Run all scenarios with and without SAMPLE_EDGE_MONITOR_ASSERT_EN -> identical outputs, zero assertion failures.

Source files
------------

// File: rtl/sample_edge_monitor.sv
// Per-channel sample change/edge monitor with stuck detection and saturating change counters.
// Define SAMPLE_EDGE_MONITOR_ASSERT_EN to compile in concurrent self-check assertions.
//
// state   | meaning
// S_INIT  | no reference sample held yet
// S_TRACK | reference held, watching for changes
// S_STUCK | reference unchanged for STABLE_MAX samples
module sample_edge_monitor #(
  parameter int CH         = 4,
  parameter int W          = 1,
  parameter int STABLE_MAX = 8,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [CH*W-1:0]     din,
  output logic [CH-1:0]       changed,
  output logic [CH-1:0]       rose,
  output logic [CH-1:0]       fell,
  output logic [CH-1:0]       stuck_err,
  output logic [CH*CNT_W-1:0] chg_cnt,
  output logic                armed
);

  localparam int SW = $clog2(STABLE_MAX + 1);
  localparam logic [SW-1:0]    STABLE_TOP = SW'(STABLE_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP    = '1;

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_STUCK} state_t;

  state_t           st_q     [CH];
  state_t           st_d     [CH];
  logic [W-1:0]     ref_q    [CH];
  logic [W-1:0]     ref_d    [CH];
  logic [SW-1:0]    stable_q [CH];
  logic [SW-1:0]    stable_d [CH];
  logic [CNT_W-1:0] cnt_q    [CH];
  logic [CNT_W-1:0] cnt_d    [CH];
  logic [CH-1:0]    stuck_q, stuck_d;
  logic [CH-1:0]    changed_q, changed_d;
  logic [CH-1:0]    rose_q, rose_d;
  logic [CH-1:0]    fell_q, fell_d;
  logic             armed_q, armed_d;
  logic [W-1:0]     sample;

  always_comb begin
    stuck_d   = stuck_q;
    changed_d = '0;
    rose_d    = '0;
    fell_d    = '0;
    armed_d   = armed_q | en;
    sample    = '0;
    for (int i = 0; i < CH; i++) begin
      st_d[i]     = st_q[i];
      ref_d[i]    = ref_q[i];
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      sample      = din[i*W +: W];
      if (en) begin
        ref_d[i] = sample;
        if (st_q[i] == S_INIT) begin
          st_d[i] = S_TRACK;
        end else if (sample != ref_q[i]) begin
          changed_d[i] = 1'b1;
          rose_d[i]    = sample[0] & ~ref_q[i][0];
          fell_d[i]    = ~sample[0] & ref_q[i][0];
          stable_d[i]  = '0;
          st_d[i]      = S_TRACK;
          if (cnt_q[i] != CNT_TOP) cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          if (stable_q[i] != STABLE_TOP) stable_d[i] = stable_q[i] + 1'b1;
          if (stable_d[i] == STABLE_TOP) begin
            stuck_d[i] = 1'b1;
            st_d[i]    = S_STUCK;
          end
        end
      end
      // clr beats any same-edge count/flag update but leaves pulses and reference alone
      if (clr) begin
        cnt_d[i]    = '0;
        stable_d[i] = '0;
        stuck_d[i]  = 1'b0;
        if (st_d[i] == S_STUCK) st_d[i] = S_TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        st_q[i]     <= S_INIT;
        ref_q[i]    <= '0;
        stable_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      stuck_q   <= '0;
      changed_q <= '0;
      rose_q    <= '0;
      fell_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        st_q[i]     <= st_d[i];
        ref_q[i]    <= ref_d[i];
        stable_q[i] <= stable_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      stuck_q   <= stuck_d;
      changed_q <= changed_d;
      rose_q    <= rose_d;
      fell_q    <= fell_d;
      armed_q   <= armed_d;
    end
  end

  assign changed   = changed_q;
  assign rose      = rose_q;
  assign fell      = fell_q;
  assign stuck_err = stuck_q;
  assign armed     = armed_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign chg_cnt[g*CNT_W +: CNT_W] = cnt_q[g];

`ifdef SAMPLE_EDGE_MONITOR_ASSERT_EN
    a_changed: assert property (@(posedge clk) disable iff (rst)
      (en && st_q[g] != S_INIT) |=> (changed[g] == $past(din[g*W +: W] != ref_q[g])))
      else $error("%0t: changed mismatch on channel %0d", $time, g);

    a_rose_fell: assert property (@(posedge clk) disable iff (rst)
      !(rose[g] && fell[g]))
      else $error("%0t: rose and fell both set on channel %0d", $time, g);

    a_stuck_sticky: assert property (@(posedge clk) disable iff (rst)
      $fell(stuck_err[g]) |-> $past(clr || rst))
      else $error("%0t: stuck_err dropped without clear on channel %0d", $time, g);

    a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
      (chg_cnt[g*CNT_W +: CNT_W] < $past(chg_cnt[g*CNT_W +: CNT_W])) |-> $past(clr || rst))
      else $error("%0t: chg_cnt decreased without clear on channel %0d", $time, g);
`endif
  end

endmodule

// File: tb/tb_sample_edge_monitor.sv
// Directed self-checking bench for sample_edge_monitor (CH=4, W=2, STABLE_MAX=3, CNT_W=4).
module tb_sample_edge_monitor;

  localparam int CH = 4, W = 2, SM = 3, CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic           clr = 1'b0;
  logic [CH*W-1:0]  din = '0;
  logic [CH-1:0]    changed, rose, fell, stuck_err;
  logic [CH*CW-1:0] chg_cnt;
  logic             armed;

  int checks = 0;
  int errors = 0;

  sample_edge_monitor #(.CH(CH), .W(W), .STABLE_MAX(SM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
    .changed(changed), .rose(rose), .fell(fell), .stuck_err(stuck_err),
    .chg_cnt(chg_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive inputs, take one posedge, sample 1ns later
  task automatic step(input logic [7:0] d, input logic e, input logic c, input logic r);
    din = d; en = e; clr = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic a, input logic [3:0] chg, input logic [3:0] ro,
                         input logic [3:0] fe, input logic [3:0] st, input logic [15:0] cnt);
    chk({tag, ".armed"},   {31'd0, armed}, {31'd0, a});
    chk({tag, ".changed"}, {28'd0, changed}, {28'd0, chg});
    chk({tag, ".rose"},    {28'd0, rose}, {28'd0, ro});
    chk({tag, ".fell"},    {28'd0, fell}, {28'd0, fe});
    chk({tag, ".stuck"},   {28'd0, stuck_err}, {28'd0, st});
    chk({tag, ".cnt"},     {16'd0, chg_cnt}, {16'd0, cnt});
  endtask

  initial begin
    // din packing: {ch3, ch2, ch1, ch0}, 2 bits each
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    chk_all("reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);

    // ch0 = 0,1,1,0 ; ch1 held at 2'b10
    step(8'h08, 1'b1, 1'b0, 1'b0);
    chk_all("arm", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    step(8'h09, 1'b1, 1'b0, 1'b0);
    chk_all("s2_rise", 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 16'h0001);
    step(8'h09, 1'b1, 1'b0, 1'b0);
    chk_all("s3_hold", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0001);
    step(8'h08, 1'b1, 1'b0, 1'b0);
    chk_all("s4_fall_stuck", 1'b1, 4'h1, 4'h0, 4'h1, 4'hE, 16'h0002);
    // ch1 10 -> 01: change leaves sticky flag set
    step(8'h04, 1'b1, 1'b0, 1'b0);
    chk_all("s5_ch1chg", 1'b1, 4'h2, 4'h2, 4'h0, 4'hE, 16'h0012);
    step(8'h04, 1'b1, 1'b1, 1'b0);
    chk_all("s6_clr", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);

    // ch2 toggles 20 times; others constant and go stuck after 3 samples
    for (int i = 0; i < 20; i++) begin
      step((i % 2 == 0) ? 8'h34 : 8'h04, 1'b1, 1'b0, 1'b0);
      if (i == 14) chk("sat_reach", {16'd0, chg_cnt}, 32'h0F00);
    end
    chk_all("sat_hold", 1'b1, 4'h4, 4'h0, 4'h4, 4'hB, 16'h0F00);

    // en low while din wanders: no pulses, nothing moves
    step(8'hFF, 1'b0, 1'b0, 1'b0);
    chk_all("en0_a", 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 16'h0F00);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'hAA, 1'b0, 1'b0, 1'b0);
    step(8'h55, 1'b0, 1'b0, 1'b0);
    step(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_all("en0_e", 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 16'h0F00);
    step(8'h04, 1'b1, 1'b0, 1'b0);
    chk_all("en1_same", 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 16'h0F00);

    // clr coincident with ch3 00 -> 11
    step(8'hC4, 1'b1, 1'b1, 1'b0);
    chk_all("clr_chg", 1'b1, 4'h8, 4'h8, 4'h0, 4'h0, 16'h0000);
    step(8'h04, 1'b1, 1'b0, 1'b0);
    chk_all("after_clr", 1'b1, 4'h8, 4'h0, 4'h8, 4'h0, 16'h1000);

    // reset mid-stream discards the reference
    step(8'h04, 1'b1, 1'b0, 1'b1);
    chk_all("mid_rst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    step(8'h05, 1'b1, 1'b0, 1'b0);
    chk_all("rearm", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    step(8'h04, 1'b1, 1'b0, 1'b0);
    chk_all("post_rst_fall", 1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
